id_ex_pipe_reg: RTL and testbench

//  ID->EX pipeline register with a two-entry skid buffer. Captures decoded operands and the

---
 rtl/id_ex_pipe_reg.sv | 163 ++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with a two-entry skid buffer (main + skid).
// The main entry drives out_*. in_ready depends only on registered state,
// so there is no combinational path from the EX side back to the ID side.
// Optional build macro: ID_EX_STATS_EN adds saturating stall/flush counters.
//
// state | meaning
// EMPTY | no entry held (main_valid=0, skid_valid=0)
// ONE   | main entry valid, skid empty
// FULL  | main and skid both valid, in_ready=0
module id_ex_pipe_reg #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic                  in_reg_wr_en,
    input  logic                  in_pc_rs1_sel,
    input  logic                  in_imm_rs2_sel,
    input  logic                  in_jump_branch_sel,
    input  logic                  in_mem_wr_en,
    input  logic [1:0]            in_reg_write_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_rs1_data,
    output logic [XLEN-1:0]       out_rs2_data,
    output logic [XLEN-1:0]       out_imm,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [2:0]            out_funct3,
    output logic [6:0]            out_funct7,
    output logic                  out_reg_wr_en,
    output logic                  out_pc_rs1_sel,
    output logic                  out_imm_rs2_sel,
    output logic                  out_jump_branch_sel,
    output logic                  out_mem_wr_en,
    output logic [1:0]            out_reg_write_ctrl
`ifdef ID_EX_STATS_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic                  reg_wr_en;
        logic                  pc_rs1_sel;
        logic                  imm_rs2_sel;
        logic                  jump_branch_sel;
        logic                  mem_wr_en;
        logic [1:0]            reg_write_ctrl;
    } payload_t;

    payload_t in_pl;
    payload_t main_pl;
    payload_t skid_pl;
    logic     main_valid;
    logic     skid_valid;
    logic     accept;
    logic     fire;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid;
    assign fire     = main_valid & out_ready;

    // Pack the incoming fields; writes to x0 are suppressed at capture time.
    always_comb begin
        in_pl                 = '0;
        in_pl.pc              = in_pc;
        in_pl.rs1_data        = in_rs1_data;
        in_pl.rs2_data        = in_rs2_data;
        in_pl.imm             = in_imm;
        in_pl.rd              = in_rd;
        in_pl.funct3          = in_funct3;
        in_pl.funct7          = in_funct7;
        in_pl.reg_wr_en       = in_reg_wr_en & (in_rd != '0);
        in_pl.pc_rs1_sel      = in_pc_rs1_sel;
        in_pl.imm_rs2_sel     = in_imm_rs2_sel;
        in_pl.jump_branch_sel = in_jump_branch_sel;
        in_pl.mem_wr_en       = in_mem_wr_en;
        in_pl.reg_write_ctrl  = in_reg_write_ctrl;
    end

    // Skid buffer state machine: reset beats flush, flush beats any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_pl    <= '0;
            skid_pl    <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                main_pl    <= in_pl;
                main_valid <= 1'b1;
            end
        end else if (!skid_valid) begin
            if (accept && fire) begin
                main_pl <= in_pl;
            end else if (accept) begin
                skid_pl    <= in_pl;
                skid_valid <= 1'b1;
            end else if (fire) begin
                main_valid <= 1'b0;
            end
        end else if (fire) begin
            main_pl    <= skid_pl;
            skid_valid <= 1'b0;
        end
    end

    // Outputs come straight from the main entry; side-effecting bits are masked in bubbles.
    always_comb begin
        out_valid           = main_valid;
        out_pc              = main_pl.pc;
        out_rs1_data        = main_pl.rs1_data;
        out_rs2_data        = main_pl.rs2_data;
        out_imm             = main_pl.imm;
        out_rd              = main_pl.rd;
        out_funct3          = main_pl.funct3;
        out_funct7          = main_pl.funct7;
        out_reg_wr_en       = main_pl.reg_wr_en & main_valid;
        out_pc_rs1_sel      = main_pl.pc_rs1_sel;
        out_imm_rs2_sel     = main_pl.imm_rs2_sel;
        out_jump_branch_sel = main_pl.jump_branch_sel & main_valid;
        out_mem_wr_en       = main_pl.mem_wr_en & main_valid;
        out_reg_write_ctrl  = main_pl.reg_write_ctrl;
    end

`ifdef ID_EX_STATS_EN
    // Saturating counters for EX back-pressure cycles and flushes that killed work.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush && (main_valid || skid_valid) && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed testbench for id_ex_pipe_reg with hand-computed expectations.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  in_rd, out_rd;
    logic [2:0]  in_funct3, out_funct3;
    logic [6:0]  in_funct7, out_funct7;
    logic        in_reg_wr_en, in_pc_rs1_sel, in_imm_rs2_sel, in_jump_branch_sel, in_mem_wr_en;
    logic        out_reg_wr_en, out_pc_rs1_sel, out_imm_rs2_sel, out_jump_branch_sel, out_mem_wr_en;
    logic [1:0]  in_reg_write_ctrl, out_reg_write_ctrl;
`ifdef ID_EX_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rd(in_rd), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_reg_wr_en(in_reg_wr_en), .in_pc_rs1_sel(in_pc_rs1_sel), .in_imm_rs2_sel(in_imm_rs2_sel),
        .in_jump_branch_sel(in_jump_branch_sel), .in_mem_wr_en(in_mem_wr_en),
        .in_reg_write_ctrl(in_reg_write_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rd(out_rd), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_reg_wr_en(out_reg_wr_en), .out_pc_rs1_sel(out_pc_rs1_sel), .out_imm_rs2_sel(out_imm_rs2_sel),
        .out_jump_branch_sel(out_jump_branch_sel), .out_mem_wr_en(out_mem_wr_en),
        .out_reg_write_ctrl(out_reg_write_ctrl)
`ifdef ID_EX_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd);
        in_valid = v;
        in_pc    = pc;
        in_rd    = rd;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        in_rd = '0; in_funct3 = '0; in_funct7 = '0;
        in_reg_wr_en = 1'b0; in_pc_rs1_sel = 1'b0; in_imm_rs2_sel = 1'b0;
        in_jump_branch_sel = 1'b0; in_mem_wr_en = 1'b0; in_reg_write_ctrl = '0;

        // 1. reset
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_reg_wr_en", out_reg_wr_en, 0);
        reset = 1'b0;

        // 2. single instruction, one-cycle latency
        out_ready = 1'b1;
        drive(1, 32'h100, 5);
        in_reg_wr_en = 1'b1; in_rs1_data = 32'h1111_2222; in_rs2_data = 32'h3333_4444;
        in_imm = 32'hFFFF_FFF0; in_funct3 = 3'b101; in_funct7 = 7'h20; in_imm_rs2_sel = 1'b1;
        tick();
        chk("t2_out_valid", out_valid, 1);
        chk("t2_out_pc", out_pc, 32'h100);
        chk("t2_out_rd", out_rd, 5);
        chk("t2_reg_wr_en", out_reg_wr_en, 1);
        chk("t2_rs1", out_rs1_data, 32'h1111_2222);
        chk("t2_rs2", out_rs2_data, 32'h3333_4444);
        chk("t2_imm", out_imm, 32'hFFFF_FFF0);
        chk("t2_funct", {out_funct7, out_funct3}, {7'h20, 3'b101});
        chk("t2_imm_sel", out_imm_rs2_sel, 1);
        in_valid = 1'b0;
        tick();
        chk("t2_drain_valid", out_valid, 0);
        chk("t2_bubble_wr_en", out_reg_wr_en, 0);
        chk("t2_hold_pc", out_pc, 32'h100);

        // 3. back-pressure fills skid, then in-order drain
        out_ready = 1'b0;
        drive(1, 32'h0, 1);
        tick();
        chk("t3_A_valid", out_valid, 1);
        chk("t3_one_ready", in_ready, 1);
        drive(1, 32'h4, 2);
        tick();
        chk("t3_full_ready", in_ready, 0);
        chk("t3_full_pc", out_pc, 32'h0);
        drive(1, 32'h8, 3);
        tick();
        chk("t3_hold_ready", in_ready, 0);
        chk("t3_hold_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        tick();
        chk("t3_B_pc", out_pc, 32'h4);
        chk("t3_B_rd", out_rd, 2);
        chk("t3_B_ready", in_ready, 1);
        tick();
        chk("t3_C_pc", out_pc, 32'h8);
        chk("t3_C_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("t3_empty", out_valid, 0);
        chk("t3_ready_back", in_ready, 1);

        // full-rate streaming with out_ready=1
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h200 + 32'(4 * i), 5'(i + 1));
            tick();
            chk("stream_pc", out_pc, 32'h200 + 32'(4 * i));
            chk("stream_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        tick();

        // 4. flush in FULL state with D offered
        out_ready = 1'b0;
        drive(1, 32'h20, 4); tick();
        drive(1, 32'h24, 6); tick();
        chk("t4_full", in_ready, 0);
        flush = 1'b1;
        drive(1, 32'hC, 7);
        tick();
        flush = 1'b0;
        chk("t4_flush_valid", out_valid, 0);
        chk("t4_flush_ready", in_ready, 1);
        chk("t4_flush_wr_en", out_reg_wr_en, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("t4_no_D_valid", out_valid, 0);
        chk("t4_no_D_pc", out_pc, 32'h20);

        // 5. rd=0 suppresses reg_wr_en; masking of side-effect bits in bubbles
        out_ready = 1'b0;
        drive(1, 32'h40, 0);
        in_reg_wr_en = 1'b1; in_reg_write_ctrl = 2'd1; in_mem_wr_en = 1'b1; in_jump_branch_sel = 1'b1;
        tick();
        chk("t5_valid", out_valid, 1);
        chk("t5_x0_wr_en", out_reg_wr_en, 0);
        chk("t5_wctrl", out_reg_write_ctrl, 1);
        chk("t5_mem_wr", out_mem_wr_en, 1);
        chk("t5_jb", out_jump_branch_sel, 1);
        in_valid = 1'b0; in_mem_wr_en = 1'b0; in_jump_branch_sel = 1'b0; out_ready = 1'b1;
        tick();
        chk("t5_bubble_mem", out_mem_wr_en, 0);
        chk("t5_bubble_jb", out_jump_branch_sel, 0);
        chk("t5_hold_wctrl", out_reg_write_ctrl, 1);

        // reset mid-transfer drops both entries and clears payload
        out_ready = 1'b0;
        drive(1, 32'h60, 8); tick();
        drive(1, 32'h64, 9); tick();
        in_valid = 1'b0; reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_pc", out_pc, 0);
        chk("mrst_wctrl", out_reg_write_ctrl, 0);
        out_ready = 1'b1;
        tick();
        chk("mrst_no_skid", out_valid, 0);

`ifdef ID_EX_STATS_EN
        // 6. counters
        reset = 1'b1; tick(); reset = 1'b0;
        chk("st_rst_stall", stall_cnt, 0);
        out_ready = 1'b0;
        in_reg_write_ctrl = 2'd0;
        drive(1, 32'h80, 1); tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("st_stall3", stall_cnt, 3);
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("st_flush1", flush_cnt, 1);
        chk("st_stall_after_flush", stall_cnt, 3);
        out_ready = 1'b0;
        drive(1, 32'h84, 2); tick();
        in_valid = 1'b0;
        for (int i = 0; i < 70000; i++) tick();
        chk("st_sat", stall_cnt, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
